// File: rtl/fact_question_gen.sv
`default_nettype none
// ============================================================================
// Module   : fact_question_gen
// Purpose  : Question generator for the factorization game. It draws three
//            prime indices from a free-running LFSR and multiplies the primes.
//            Products above MAX_PRODUCT are redrawn, up to RETRY_MAX times.
//            After that a fixed fallback question (2*2*2) is used. The
//            accepted product is converted to six BCD digits.
// Ports    : CLK      in   system clock, rising edge
//            RST      in   asynchronous active-low reset
//            REQ      in   new-question request, sampled only when idle
//            BUSY     out  high while a question is being generated
//            VALID    out  1-cycle pulse, QUESTION/ANSWER updated
//            QUESTION out  24-bit BCD product, [3:0] = units
//            ANSWER   out  sorted prime indices, [2:0] smallest
// Revision : 1.0 - initial release
// ============================================================================
module fact_question_gen #(
  parameter int          MAX_PRODUCT = 999,
  parameter int          RETRY_MAX   = 15,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  output logic        BUSY,
  output logic        VALID,
  output logic [23:0] QUESTION,
  output logic [8:0]  ANSWER
);

  localparam int            RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [12:0]   PROD_LIM  = 13'(MAX_PRODUCT);

  typedef enum logic [2:0] {IDLE, DRAW, MUL, CHECK, BCD, DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   lfsr;
  logic [RW-1:0] retry;
  logic [3:0]    cnt;
  logic [2:0]    idx0, idx1, idx2;
  logic [12:0]   prod;
  logic [8:0]    ans;
  // Double-dabble work register: {BCD digits[23:0], binary[12:0]}
  logic [36:0]   dd;

  logic          lfsr_fb;
  logic          accept;
  logic          prod_ok;
  logic          retry_left;
  logic [8:0]    pair;
  logic [2:0]    s_a, s_b, s_c;

  function automatic logic [4:0] prime(input logic [2:0] i);
    case (i)
      3'd0:    prime = 5'd2;
      3'd1:    prime = 5'd3;
      3'd2:    prime = 5'd5;
      3'd3:    prime = 5'd7;
      3'd4:    prime = 5'd11;
      3'd5:    prime = 5'd13;
      3'd6:    prime = 5'd17;
      default: prime = 5'd19;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  function automatic logic [36:0] dabble_step(input logic [36:0] v);
    logic [36:0] t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (t[13+4*i +: 4] >= 4'd5) t[13+4*i +: 4] = t[13+4*i +: 4] + 4'd3;
    end
    return {t[35:0], 1'b0};
  endfunction

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // A request arriving during the VALID cycle is held off by one edge, so
  // back-to-back questions under a held REQ are 22 cycles apart.
  assign accept     = (state == IDLE) && REQ && !VALID;
  assign prod_ok    = (prod <= PROD_LIM);
  assign retry_left = (retry < RETRY_LIM);
  assign pair       = 9'(prime(idx0)) * 9'(prime(idx1));

  // Three-element compare-swap network; s_a ends up smallest.
  always_comb begin
    s_a = idx0;
    s_b = idx1;
    s_c = idx2;
    if (s_a > s_b) {s_a, s_b} = {s_b, s_a};
    if (s_b > s_c) {s_b, s_c} = {s_c, s_b};
    if (s_a > s_b) {s_a, s_b} = {s_b, s_a};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = DRAW;
      DRAW:  if (cnt == 4'd2) state_next = MUL;
      MUL:   if (cnt == 4'd1) state_next = CHECK;
      CHECK: state_next = (!prod_ok && retry_left) ? DRAW : BCD;
      BCD:   if (cnt == 4'd12) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr     <= SEED;
      retry    <= '0;
      cnt      <= '0;
      idx0     <= '0;
      idx1     <= '0;
      idx2     <= '0;
      prod     <= '0;
      ans      <= '0;
      dd       <= '0;
      BUSY     <= 1'b0;
      VALID    <= 1'b0;
      QUESTION <= '0;
      ANSWER   <= '0;
    end else begin
      // Free-running in every state so request timing perturbs the draw.
      lfsr  <= {lfsr[14:0], lfsr_fb};
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            BUSY  <= 1'b1;
            retry <= '0;
            cnt   <= '0;
          end
        end
        DRAW: begin
          case (cnt)
            4'd0:    idx0 <= lfsr[2:0];
            4'd1:    idx1 <= lfsr[2:0];
            default: idx2 <= lfsr[2:0];
          endcase
          cnt <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
        end
        MUL: begin
          if (cnt == 4'd0) begin
            prod <= {4'd0, pair};
            cnt  <= 4'd1;
          end else begin
            prod <= prod * 13'(prime(idx2));
            cnt  <= 4'd0;
          end
        end
        CHECK: begin
          cnt <= '0;
          if (prod_ok) begin
            ans <= {s_c, s_b, s_a};
            dd  <= {24'd0, prod};
          end else if (retry_left) begin
            retry <= retry + RW'(1);
          end else begin
            idx0 <= '0;
            idx1 <= '0;
            idx2 <= '0;
            prod <= 13'd8;
            ans  <= '0;
            dd   <= {24'd0, 13'd8};
          end
        end
        BCD: begin
          dd  <= dabble_step(dd);
          cnt <= (cnt == 4'd12) ? 4'd0 : cnt + 4'd1;
        end
        DONE: begin
          QUESTION <= dd[36:13];
          ANSWER   <= ans;
          VALID    <= 1'b1;
          BUSY     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fact_question_gen.md
# fact_question_gen

Question generator for the factorization game. It draws three prime factors from a free-running LFSR and multiplies them. It rejects products above a limit, converts the accepted product to six BCD digits, and returns it with the sorted factor list. It sits between the round controller, which pulses a request when a new round starts, and the question display/answer-checking logic, which consumes the 24-bit BCD question and the factor answer.

## Interface
Parameters:
- MAX_PRODUCT, 999: largest accepted product (binary, 13-bit range).
- RETRY_MAX, 15: failed checks tolerated before the fallback question is used.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  1  request a new question; sampled only in IDLE; 1-cycle pulse expected, level tolerated.
- BUSY  out  1  high while a question is being generated.
- VALID  out  1  1-cycle pulse: QUESTION/ANSWER updated this cycle.
- QUESTION  out  24  six BCD digits of the product, [3:0] = units, zero-padded.
- ANSWER  out  9  three 3-bit prime indices, ascending: [2:0] smallest, [8:6] largest.

## Operation
- Prime table by index 0..7: 2, 3, 5, 7, 11, 13, 17, 19.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Shifts every cycle in every state, so request timing adds entropy.
- States: IDLE, DRAW, MUL, CHECK, BCD, DONE.
- IDLE: on REQ=1 go to DRAW, set BUSY, clear the retry counter. With REQ=0, stay.
- DRAW: 3 cycles. Each cycle captures LFSR[2:0] into idx0, idx1, idx2 in turn. Repeated indices are allowed.
- MUL, 2 cycles:
  - cycle 1: p = prime[idx0]*prime[idx1], 9 bits.
  - cycle 2: p = p*prime[idx2], 13 bits, max 6859; no overflow possible.
- CHECK, 1 cycle:
  - If p ≤ MAX_PRODUCT: latch the sorted indices (3-element compare-swap) into an answer register, then go to BCD.
  - Else, if retry counter < RETRY_MAX: increment it and go to DRAW.
  - Else (fallback): force idx = 0,0,0 and p = 8, then go to BCD.
- BCD: double-dabble over 13 iterations, one per cycle. Add-3 to any nibble ≥ 5, then shift.
- DONE, 1 cycle:
  - Register QUESTION ← BCD result and ANSWER ← sorted indices.
  - Assert VALID, drop BUSY, return to IDLE.
- REQ while BUSY is ignored; no queuing.
- QUESTION/ANSWER hold their last values until the next DONE.

## Timing
Reset values (RST=0, async): state IDLE, BUSY=0, VALID=0, QUESTION=0, ANSWER=0, LFSR=SEED, retry counter=0, internal regs 0.

Latency, counting the edge that samples REQ in IDLE as edge 0:
- Edges 1–3: DRAW captures.
- Edges 4–5: MUL.
- Edge 6: CHECK decision.
- Edges 7–19: BCD iterations.
- Edge 20: DONE; VALID=1 and QUESTION/ANSWER new during the cycle after edge 20.
- Each retry adds 6 cycles (DRAW+MUL+CHECK).
- Fallback case: VALID at edge 20 + 6·RETRY_MAX (110 at defaults).

Handshake and boundary rules:
- BUSY=1 from edge 0 up to and including the cycle before VALID; BUSY=0 in the VALID cycle.
- REQ held high continuously: a new request is accepted on the edge after the VALID cycle.
- Back-to-back questions are therefore ≥ 22 cycles apart.
- Reset asserted mid-generation: immediate return to reset values, no VALID, and previous QUESTION is cleared.
- REQ on the same edge as reset release: ignored; the first accepted REQ is on a later edge.

## Test plan
- Reset: drive RST=0 mid-BCD, with LFSR at SEED → all outputs 0 and BUSY=0 asynchronously; no VALID within 200 cycles after release with REQ=0.
- Nominal, defaults: REQ pulse → BUSY for ≥ 20 cycles, then one VALID. Check:
  - product of prime[ANSWER fields] ≤ 999;
  - QUESTION equals the BCD of that product, with QUESTION[23:12]=0;
  - ANSWER fields are non-decreasing.
- MAX_PRODUCT=6859: 50 requests → every VALID exactly 20 cycles after its REQ edge, with QUESTION ≤ 24'h006859.
- MAX_PRODUCT=0: REQ → VALID at edge 110, QUESTION=24'h000008, ANSWER=9'b000_000_000.
- REQ pulses during BUSY plus REQ held high for 100 cycles → extra pulses ignored; held REQ gives VALIDs spaced exactly 22 cycles apart when no retries occur (MAX_PRODUCT=6859).
- BCD corner: force the fallback path, and separately a run producing 19·19·19 (MAX_PRODUCT=6859) → QUESTION=24'h006859, ANSWER=9'b111_111_111.
